// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared types and constants for the perceptron engine.
// Holds the FSM state enum, data width, default sizes and classify().
package perceptron_pkg;

  localparam int DATA_W    = 8;
  localparam int DEF_DIM   = 2;
  localparam int DEF_ACC_W = 20;

  typedef enum logic [2:0] {
    ST_UNCFG,
    ST_LOAD,
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_RESULT
  } state_t;

  // Positive means sign clear and value non-zero.
  function automatic logic classify(
    input logic sign_bit,
    input logic nonzero
  );
    return !sign_bit && nonzero;
  endfunction

endpackage

// File: rtl/perceptron_mac.sv
// perceptron_mac: signed 8x8 multiply, sign-extend, add to bias or acc.
// Ports: i_init picks bias (1) or i_acc (0) as addend; o_sum is the result.
module perceptron_mac
  import perceptron_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_W
) (
  input  logic                 i_init,
  input  logic [DATA_W-1:0]    i_x,
  input  logic [DATA_W-1:0]    i_w,
  input  logic [DATA_W-1:0]    i_bias,
  input  logic [ACC_WIDTH-1:0] i_acc,
  output logic [ACC_WIDTH-1:0] o_sum
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0]  w_xe;
  logic signed [PW-1:0]  w_we;
  logic signed [PW-1:0]  w_prod;
  logic [ACC_WIDTH-1:0]  w_prod_ext;
  logic [ACC_WIDTH-1:0]  w_bias_ext;
  logic [ACC_WIDTH-1:0]  w_base;

  assign w_xe   = PW'($signed(i_x));
  assign w_we   = PW'($signed(i_w));
  assign w_prod = w_xe * w_we;

  assign w_prod_ext = {{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod};
  assign w_bias_ext = {{(ACC_WIDTH-DATA_W){i_bias[DATA_W-1]}}, i_bias};

  assign w_base = i_init ? w_bias_ext : i_acc;
  assign o_sum  = w_base + w_prod_ext;

endmodule

// File: rtl/perceptron_infer.sv
// perceptron_infer: streaming single-layer perceptron inference engine.
// Ports: cfg_* weight/bias load, s_* sample stream, m_* result, status.
module perceptron_infer
  import perceptron_pkg::*;
#(
  parameter int DIM       = DEF_DIM,
  parameter int ACC_WIDTH = DEF_ACC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  input  logic [DATA_W-1:0]    cfg_data,
  output logic                 cfg_ready,
  input  logic                 s_valid,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_class,
  output logic [ACC_WIDTH-1:0] m_score,
  output logic                 weights_ok,
  output logic                 err_len
);

  localparam int IW = $clog2(DIM + 1);
  localparam logic [IW-1:0] BIAS_IDX = IW'(DIM);
  localparam logic [IW-1:0] LAST_EL  = IW'(DIM - 1);

  state_t r_state;
  state_t w_nxt;

  logic [DATA_W-1:0]    r_w [DIM+1];
  logic [IW-1:0]        r_idx;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_class;
  logic                 r_ok;
  logic                 r_err;
  logic                 r_cfg_rdy;
  logic                 r_s_rdy;
  logic                 r_m_vld;

  logic                 w_idle;
  logic                 w_cfg_fire;
  logic                 w_take;
  logic                 w_at_last;
  logic                 w_bad;
  logic [IW-1:0]        w_elem;
  logic [IW-1:0]        w_widx;
  logic [ACC_WIDTH-1:0] w_sum;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_cfg_fire = cfg_valid & r_cfg_rdy;
  // A config beat in IDLE wins over a concurrent sample beat.
  assign w_take = s_valid &
    ((r_state == ST_ACCUM) | (w_idle & ~cfg_valid));
  // r_idx doubles as load index and element index.
  assign w_elem    = w_idle ? '0 : r_idx;
  assign w_at_last = (w_elem == LAST_EL);
  assign w_bad     = w_at_last ? ~s_last : s_last;
  assign w_widx    = (r_state == ST_LOAD) ? r_idx : '0;

  perceptron_mac #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .i_init (w_idle),
    .i_x    (s_data),
    .i_w    (r_w[w_elem]),
    .i_bias (r_w[DIM]),
    .i_acc  (r_acc),
    .o_sum  (w_sum)
  );

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_UNCFG: begin
        if (w_cfg_fire) w_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_cfg_fire && r_idx == BIAS_IDX)
          w_nxt = ST_IDLE;
      end
      ST_IDLE, ST_ACCUM: begin
        if (w_idle && w_cfg_fire) begin
          w_nxt = ST_LOAD;
        end else if (w_take) begin
          if (w_bad)
            w_nxt = w_at_last ? ST_DRAIN : ST_IDLE;
          else
            w_nxt = w_at_last ? ST_RESULT : ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        if (s_valid && s_last) w_nxt = ST_IDLE;
      end
      ST_RESULT: begin
        if (m_ready) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_UNCFG;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_UNCFG;
      r_idx     <= '0;
      r_acc     <= '0;
      r_class   <= 1'b0;
      r_ok      <= 1'b0;
      r_err     <= 1'b0;
      r_cfg_rdy <= 1'b1;
      r_s_rdy   <= 1'b0;
      r_m_vld   <= 1'b0;
      for (int i = 0; i <= DIM; i++)
        r_w[i] <= '0;
    end else begin
      r_state   <= w_nxt;
      r_cfg_rdy <= (w_nxt == ST_UNCFG) |
                   (w_nxt == ST_LOAD) |
                   (w_nxt == ST_IDLE);
      r_s_rdy   <= (w_nxt == ST_IDLE) |
                   (w_nxt == ST_ACCUM) |
                   (w_nxt == ST_DRAIN);
      r_m_vld   <= (w_nxt == ST_RESULT);
      r_err     <= w_take & w_bad;
      if (w_cfg_fire) begin
        r_w[w_widx] <= cfg_data;
        r_idx       <= w_widx + 1'b1;
        r_ok        <= (r_state == ST_LOAD) &&
                       (r_idx == BIAS_IDX);
      end else if (w_take) begin
        r_idx <= w_elem + 1'b1;
        if (!w_bad) r_acc <= w_sum;
        if (!w_bad && w_at_last)
          r_class <= classify(w_sum[ACC_WIDTH-1], |w_sum);
      end
    end
  end

  assign cfg_ready  = r_cfg_rdy;
  assign s_ready    = r_s_rdy;
  assign m_valid    = r_m_vld;
  assign m_class    = r_class;
  assign m_score    = r_acc;
  assign weights_ok = r_ok;
  assign err_len    = r_err;

endmodule

// File: tb/tb_perceptron_infer.sv
// tb_perceptron_infer: directed bench with a transaction-level model
// that scores whole samples and is compared against the DUT each cycle.
module tb_perceptron_infer;

  localparam int DIM = 2;
  localparam int ACC = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_valid;
  logic [7:0]     cfg_data;
  logic           cfg_ready;
  logic           s_valid;
  logic [7:0]     s_data;
  logic           s_last;
  logic           s_ready;
  logic           m_valid;
  logic           m_ready;
  logic           m_class;
  logic [ACC-1:0] m_score;
  logic           weights_ok;
  logic           err_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  perceptron_infer #(
    .DIM       (DIM),
    .ACC_WIDTH (ACC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_class    (m_class),
    .m_score    (m_score),
    .weights_ok (weights_ok),
    .err_len    (err_len)
  );

  // Model: weights, a list of pending sample elements, and flags.
  int mw [DIM+1];
  int cur [$];
  bit m_have = 0;
  bit m_loading = 0;
  bit m_drain = 0;
  bit m_pend = 0;
  int m_ld = 0;
  bit e_err = 0;
  bit e_class = 0;
  logic signed [ACC-1:0] e_score = '0;
  bit c_took = 0;
  bit s_took = 0;

  function automatic bit f_cfg_rdy();
    return !m_pend && !m_drain && cur.size() == 0;
  endfunction

  function automatic bit f_s_rdy();
    return m_have && !m_pend;
  endfunction

  task automatic chk(input string n,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d at %0t",
               n, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin : model
    bit cr;
    bit sr;
    int sum;
    if (rst) begin
      foreach (mw[i]) mw[i] = 0;
      cur.delete();
      m_have = 0; m_loading = 0; m_drain = 0;
      m_pend = 0; m_ld = 0; e_err = 0;
      c_took = 0; s_took = 0;
    end else begin
      cr = f_cfg_rdy();
      sr = f_s_rdy();
      c_took = cfg_valid && cr;
      s_took = s_valid && sr && !c_took;
      e_err = 0;
      if (m_pend && m_ready) m_pend = 0;
      if (c_took) begin
        if (!m_loading) begin
          m_loading = 1; m_ld = 0; m_have = 0;
        end
        mw[m_ld] = int'($signed(cfg_data));
        m_ld++;
        if (m_ld == DIM + 1) begin
          m_loading = 0; m_have = 1;
        end
      end else if (s_took) begin
        if (m_drain) begin
          if (s_last) m_drain = 0;
        end else begin
          cur.push_back(int'($signed(s_data)));
          if (cur.size() == DIM) begin
            if (s_last) begin
              sum = mw[DIM];
              for (int i = 0; i < DIM; i++)
                sum += cur[i] * mw[i];
              e_score = ACC'(sum);
              e_class = (e_score > 0);
              m_pend = 1;
            end else begin
              e_err = 1; m_drain = 1;
            end
            cur.delete();
          end else if (s_last) begin
            e_err = 1;
            cur.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cfg_ready", cfg_ready, f_cfg_rdy());
    chk("s_ready", s_ready, f_s_rdy());
    chk("m_valid", m_valid, m_pend);
    chk("weights_ok", weights_ok, m_have);
    chk("err_len", err_len, e_err);
    if (m_pend) begin
      chk("m_score", $signed(m_score), e_score);
      chk("m_class", m_class, e_class);
    end
  end

  task automatic cfg_beat(input int v);
    int n = 0;
    cfg_valid = 1; cfg_data = 8'(v);
    do begin
      @(negedge clk); n++;
    end while (!c_took && n < 20);
    cfg_valid = 0;
    checks++;
    if (!c_took) begin
      errors++;
      $display("FAIL cfg_accept: got none, want accept");
    end
  endtask

  task automatic s_beat(input int x, input bit last);
    int n = 0;
    s_valid = 1; s_data = 8'(x); s_last = last;
    do begin
      @(negedge clk); n++;
    end while (!s_took && n < 20);
    s_valid = 0; s_last = 0;
    checks++;
    if (!s_took) begin
      errors++;
      $display("FAIL s_accept: got none, want accept");
    end
  endtask

  task automatic load(input int w0, input int w1, input int b);
    cfg_beat(w0);
    cfg_beat(w1);
    cfg_beat(b);
  endtask

  task automatic expect_res(input int sc, input bit cl);
    int n = 0;
    while (m_valid !== 1'b1 && n < 10) begin
      @(negedge clk); n++;
    end
    chk("res_latency", n, 0);
    chk("res_valid", m_valid, 1);
    chk("res_score", $signed(m_score), sc);
    chk("res_class", m_class, cl);
    chk("model_score", e_score, sc);
  endtask

  initial begin
    rst = 1; cfg_valid = 0; cfg_data = 0;
    s_valid = 0; s_data = 0; s_last = 0; m_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_score", m_score, 0);
    chk("rst_m_class", m_class, 0);
    chk("rst_wok", weights_ok, 0);
    chk("rst_err", err_len, 0);
    rst = 0;
    @(negedge clk);

    load(4, 9, -10);
    chk("wok_after_load", weights_ok, 1);
    s_beat(2, 0); s_beat(3, 1);
    expect_res(25, 1);
    s_beat(-4, 0); s_beat(1, 1);
    expect_res(-17, 0);
    load(1, -1, 0);
    s_beat(5, 0); s_beat(5, 1);
    expect_res(0, 0);

    // Back-pressure on the result port.
    load(4, 9, -10);
    s_beat(2, 0);
    m_ready = 0;
    s_beat(3, 1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_score", $signed(m_score), 25);
      chk("hold_class", m_class, 1);
      chk("hold_s_ready", s_ready, 0);
      @(negedge clk);
    end
    m_ready = 1;
    @(negedge clk);
    chk("hold_consumed", m_valid, 0);

    // Early s_last, then a good sample.
    s_beat(7, 1);
    chk("early_err", err_len, 1);
    chk("early_noval", m_valid, 0);
    @(negedge clk);
    chk("early_err_off", err_len, 0);
    s_beat(2, 0); s_beat(3, 1);
    expect_res(25, 1);

    // Overlong sample: error at element 1, beat 3 drained.
    s_beat(1, 0); s_beat(2, 0);
    chk("long_err", err_len, 1);
    s_beat(3, 1);
    chk("drain_no_err", err_len, 0);
    repeat (2) begin
      @(negedge clk);
      chk("drain_noval", m_valid, 0);
    end

    // Asynchronous reset in the middle of a sample.
    s_beat(2, 0);
    #2 rst = 1;
    #1;
    chk("arst_cfg_ready", cfg_ready, 1);
    chk("arst_s_ready", s_ready, 0);
    chk("arst_m_valid", m_valid, 0);
    chk("arst_m_score", m_score, 0);
    chk("arst_m_class", m_class, 0);
    chk("arst_wok", weights_ok, 0);
    chk("arst_err", err_len, 0);
    @(negedge clk);
    rst = 0;
    s_valid = 1; s_data = 8'd2; s_last = 0;
    repeat (3) begin
      @(negedge clk);
      chk("refuse_s_ready", s_ready, 0);
      chk("refuse_model", s_took, 0);
    end
    s_valid = 0;
    load(4, 9, -10);
    s_beat(2, 0); s_beat(3, 1);
    expect_res(25, 1);

    // Reload between samples.
    cfg_beat(-1);
    chk("reload_wok0", weights_ok, 0);
    cfg_beat(-1);
    chk("reload_wok1", weights_ok, 0);
    cfg_beat(1);
    chk("reload_wok2", weights_ok, 1);
    s_beat(2, 0); s_beat(3, 1);
    expect_res(-4, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
